// File: rtl/program_counter_gen_if.sv
// Control, load and status signals between the CPU sequencer and the program counter.
// The tri-state address bus is a separate module port so its high-Z drive stays local to the PC.
interface program_counter_gen_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              en;
  logic              inc;
  logic              ld_byte;
  logic              ld_abort;
  logic [DATA_W-1:0] data_bus;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] pc_q;
  logic              ld_busy;
  logic              ld_done;
  logic              stk_ovf;
  logic              stk_unf;

  modport master (
    output en, inc, ld_byte, ld_abort, data_bus, call, ret,
    input  pc_q, ld_busy, ld_done, stk_ovf, stk_unf
  );

  modport slave (
    input  en, inc, ld_byte, ld_abort, data_bus, call, ret,
    output pc_q, ld_busy, ld_done, stk_ovf, stk_unf
  );
endinterface

// File: rtl/program_counter_gen.sv
// 8085-class program counter: increment, byte-wise jump-target load (LSB beat first), tri-state address drive.
// Define PC_RET_STACK_EN to add a STK_DEPTH-entry return-address stack for CALL/RET.
module program_counter_gen #(
  parameter int                 ADDR_W    = 16,
  parameter int                 DATA_W    = 8,
  parameter logic [ADDR_W-1:0]  RST_VEC   = '0,
  parameter int                 STK_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  program_counter_gen_if.slave bus,
  output wire  [ADDR_W-1:0]   addr_bus
);
  localparam int BEATS = ADDR_W / DATA_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0] staging_q, staging_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ld_done_q, ld_done_d;
  logic [ADDR_W-1:0] target;
  logic              last_beat;
  logic              commit;
  logic              ret_win;
  logic              pop_ok;
  logic [ADDR_W-1:0] stk_top;

  assign last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));

  // Current staging with the incoming beat dropped into the slice selected by beat_cnt.
  always_comb begin
    target = staging_q;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_cnt_q == CNT_W'(b)) target[b*DATA_W +: DATA_W] = bus.data_bus;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    staging_d  = staging_q;
    commit     = 1'b0;
    if (state_q == ST_LOAD && bus.ld_abort) begin
      state_d    = ST_IDLE;
      beat_cnt_d = '0;
    end else if (bus.ld_byte) begin
      if (last_beat) begin
        commit     = 1'b1;
        state_d    = ST_IDLE;
        beat_cnt_d = '0;
      end else begin
        staging_d  = target;
        state_d    = ST_LOAD;
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

`ifdef PC_RET_STACK_EN
  localparam int SP_W = $clog2(STK_DEPTH + 1);

  logic [ADDR_W-1:0] stk_mem [STK_DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push_wr;

  assign ret_win = bus.ret && !commit;

  always_comb begin
    stk_top = '0;
    for (int i = 0; i < STK_DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) stk_top = stk_mem[i];
    end
  end

  always_comb begin
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_wr = 1'b0;
    pop_ok  = 1'b0;
    if (commit && bus.call) begin
      if (sp_q == SP_W'(STK_DEPTH)) begin
        ovf_d = 1'b1;
      end else begin
        push_wr = 1'b1;
        sp_d    = sp_q + 1'b1;
      end
    end else if (ret_win) begin
      if (sp_q == '0) begin
        unf_d = 1'b1;
      end else begin
        pop_ok = 1'b1;
        sp_d   = sp_q - 1'b1;
      end
    end
  end

  // NOTE: the stack storage is not reset; the pointer alone defines which entries are valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STK_DEPTH; i++) begin
      if (push_wr && sp_q == SP_W'(i)) stk_mem[i] <= pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.stk_ovf = ovf_q;
  assign bus.stk_unf = unf_q;
`else
  logic unused_stk;

  assign unused_stk  = bus.call ^ bus.ret;
  assign ret_win     = 1'b0;
  assign pop_ok      = 1'b0;
  assign stk_top     = '0;
  assign bus.stk_ovf = 1'b0;
  assign bus.stk_unf = 1'b0;
`endif

  // Commit beats ret beats inc; a failed pop still wins and holds pc.
  always_comb begin
    pc_d      = pc_q;
    ld_done_d = commit;
    if (commit) begin
      pc_d = target;
    end else if (ret_win) begin
      if (pop_ok) pc_d = stk_top;
    end else if (bus.inc) begin
      pc_d = pc_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      staging_q  <= '0;
      pc_q       <= RST_VEC;
      ld_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      staging_q  <= staging_d;
      pc_q       <= pc_d;
      ld_done_q  <= ld_done_d;
    end
  end

  assign bus.pc_q    = pc_q;
  assign bus.ld_busy = (state_q == ST_LOAD);
  assign bus.ld_done = ld_done_q;
  assign addr_bus    = bus.en ? pc_q : 'z;
endmodule

// File: tb/tb_program_counter_gen.sv
// Directed bench for program_counter_gen: a reference model pushes expected state per cycle to a scoreboard.
// Honours PC_RET_STACK_EN the same way the design does.
module tb_program_counter_gen;
  localparam int STK_DEPTH = 4;

  typedef struct {
    string       tag;
    logic [15:0] pc;
    logic        busy;
    logic        done;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  wire  [15:0] addr_bus;
  int          total = 0;
  int          bad   = 0;

  exp_t        sb[$];
  logic [15:0] m_pc;
  logic        m_busy;
  logic [7:0]  m_lo;
  logic        m_done;
  logic        m_ovf;
  logic        m_unf;
  logic [15:0] m_stk[$];

  program_counter_gen_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  program_counter_gen #(
    .ADDR_W(16), .DATA_W(8), .RST_VEC(16'h0000), .STK_DEPTH(STK_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .addr_bus(addr_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Next-state reference written straight from the behavioural description (BEATS = 2).
  task automatic model(input logic r, i, lb, ab, input logic [7:0] d, input logic c, rt);
    logic        commit;
    logic [15:0] tgt;
    commit = 1'b0;
    tgt    = 16'h0000;
    if (r) begin
      m_pc = 16'h0000; m_busy = 1'b0; m_lo = 8'h00; m_done = 1'b0;
      m_ovf = 1'b0; m_unf = 1'b0; m_stk.delete();
      return;
    end
    if (m_busy && ab) begin
      m_busy = 1'b0;
    end else if (lb && !m_busy) begin
      m_lo   = d;
      m_busy = 1'b1;
    end else if (lb) begin
      commit = 1'b1;
      tgt    = {d, m_lo};
      m_busy = 1'b0;
    end
    m_done = commit;
    if (commit) begin
`ifdef PC_RET_STACK_EN
      if (c) begin
        if (m_stk.size() == STK_DEPTH) m_ovf = 1'b1;
        else m_stk.push_back(m_pc + 16'd1);
      end
`endif
      m_pc = tgt;
`ifdef PC_RET_STACK_EN
    end else if (rt) begin
      if (m_stk.size() == 0) m_unf = 1'b1;
      else m_pc = m_stk.pop_back();
`endif
    end else if (i) begin
      m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic step(input string tag, input logic r, i, lb, ab, input logic [7:0] d,
                      input logic c, rt);
    exp_t e;
    reset        = r;
    bus.inc      = i;
    bus.ld_byte  = lb;
    bus.ld_abort = ab;
    bus.data_bus = d;
    bus.call     = c;
    bus.ret      = rt;
    model(r, i, lb, ab, d, c, rt);
    e.tag  = tag;
    e.pc   = m_pc;
    e.busy = m_busy;
    e.done = m_done;
    e.ovf  = m_ovf;
    e.unf  = m_unf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".pc"},   bus.pc_q,             e.pc);
    check({e.tag, ".busy"}, {15'd0, bus.ld_busy}, {15'd0, e.busy});
    check({e.tag, ".done"}, {15'd0, bus.ld_done}, {15'd0, e.done});
    check({e.tag, ".ovf"},  {15'd0, bus.stk_ovf}, {15'd0, e.ovf});
    check({e.tag, ".unf"},  {15'd0, bus.stk_unf}, {15'd0, e.unf});
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic ld(input string tag, input logic [7:0] d, input logic c);
    step(tag, 1'b0, 1'b0, 1'b1, 1'b0, d, c, 1'b0);
  endtask

  task automatic ret_op(input string tag, input logic i);
    step(tag, 1'b0, i, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; bus.en = 1'b1; bus.inc = 1'b0; bus.ld_byte = 1'b0; bus.ld_abort = 1'b0;
    bus.data_bus = 8'h00; bus.call = 1'b0; bus.ret = 1'b0;
    m_pc = 16'hDEAD; m_busy = 1'b0; m_lo = 8'h00; m_done = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

    step("rst0", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step("rst1", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("addr_rst", addr_bus, 16'h0000);

    repeat (3) step("inc", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("pc_inc3", bus.pc_q, 16'h0003);
    bus.en = 1'b0; #1;
    check("addr_hiz", {15'd0, (addr_bus !== m_pc)}, 16'd1);
    bus.en = 1'b1; #1;
    check("addr_en", addr_bus, m_pc);

    ld("ff_lo", 8'hFF, 1'b0);
    ld("ff_hi", 8'hFF, 1'b0);
    check("pc_ffff", bus.pc_q, 16'hFFFF);
    step("wrap", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("pc_wrap", bus.pc_q, 16'h0000);

    ld("t3_lo", 8'h34, 1'b0);
    ld("t3_hi", 8'h12, 1'b0);
    check("pc_1234", bus.pc_q, 16'h1234);
    idle("t3_after");

    ld("t4_lo", 8'h34, 1'b0);
    step("t4_abort", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    ld("t4_lo2", 8'hAA, 1'b0);
    ld("t4_hi2", 8'hBB, 1'b0);
    check("pc_bbaa", bus.pc_q, 16'hBBAA);

    step("abort_idle_inc", 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    step("beat_inc", 1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    idle("load_hold0");
    idle("load_hold1");
    step("abort_prio", 1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
    step("lo_inc", 1'b0, 1'b1, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
    step("commit_inc", 1'b0, 1'b1, 1'b1, 1'b0, 8'h66, 1'b0, 1'b0);
    check("pc_6655", bus.pc_q, 16'h6655);

    ld("t5a_lo", 8'h00, 1'b0);
    ld("t5a_hi", 8'h01, 1'b0);
    step("call_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    ld("t5_lo", 8'h00, 1'b0);
    ld("t5_call", 8'h20, 1'b1);
    check("pc_2000", bus.pc_q, 16'h2000);
    ret_op("t5_ret", 1'b0);

    for (int k = 1; k <= 5; k++) begin
      ld("c_lo", 8'h00, 1'b0);
      ld("c_call", 8'(k * 16), 1'b1);
    end
    for (int k = 0; k < 5; k++) ret_op("ret", 1'b0);
    ret_op("ret_inc_empty", 1'b1);

    ld("mid_lo", 8'h77, 1'b0);
    step("mid_reset", 1'b1, 1'b1, 1'b1, 1'b0, 8'h88, 1'b1, 1'b0);
    check("pc_after_rst", bus.pc_q, 16'h0000);
    idle("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
